// File: rtl/vip_pool_top.sv
// Image front-end: input pixel FIFO, per-pixel channel max, 32x32 tile max-pool
// and a first-word-fall-through result FIFO tagged with an end-of-image flag.
module vip_pool_top #(
  parameter int WIDTH      = 224,
  parameter int HEIGHT     = 224,
  parameter int DATA_WIDTH = 32,
  parameter int IN_DEPTH   = 16,
  parameter int OUT_DEPTH  = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] fifo_in_data_0,
  input  logic [DATA_WIDTH-1:0] fifo_in_data_1,
  input  logic [DATA_WIDTH-1:0] fifo_in_data_2,
  input  logic                  fifo_in_wrreq,
  output logic                  fifo_in_full,
  output logic [DATA_WIDTH:0]   fifo_out_data,
  input  logic                  fifo_out_rdreq,
  output logic                  fifo_out_empty
);

  localparam int DW  = DATA_WIDTH;
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int NB  = WIDTH >> 5;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT);

  localparam logic [IAW:0]  IN_FULL   = (IAW+1)'(IN_DEPTH);
  localparam logic [IAW:0]  IN_ONE    = (IAW+1)'(1);
  localparam logic [OAW:0]  OUT_FULL  = (OAW+1)'(OUT_DEPTH);
  localparam logic [OAW:0]  OUT_ONE   = (OAW+1)'(1);
  localparam logic [OAW:0]  OUT_LIMIT = (OAW+1)'(OUT_DEPTH - 2);
  localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Input FIFO state
  logic [3*DW-1:0]      in_mem_q [IN_DEPTH];
  logic [IAW-1:0]       in_wr_ptr_q, in_rd_ptr_q;
  logic [IAW:0]         in_cnt_q, in_cnt_d;
  logic                 in_full_q, in_empty_q;
  logic                 in_wr_s, in_pop_s;
  logic [3*DW-1:0]      in_head_s;
  logic signed [DW-1:0] pix_s;

  // Position counters and stage register
  logic [XW-1:0]        x_q;
  logic [YW-1:0]        y_q;
  logic                 st_valid_q, st_first_q, st_last_q, st_class_q;
  logic [BW-1:0]        st_bx_q;
  logic signed [DW-1:0] st_p_q;

  // Accumulators
  logic signed [DW-1:0] acc_q [NB];
  logic signed [DW-1:0] acc_cur_s, acc_new_s;
  logic                 push_s;
  logic [DW:0]          push_data_s;

  // Output FIFO state
  logic [DW:0]          out_mem_q [OUT_DEPTH];
  logic [OAW-1:0]       out_wr_ptr_q, out_rd_ptr_q, out_rd_nxt_s;
  logic [OAW:0]         out_cnt_q, out_cnt_d;
  logic                 out_empty_q;
  logic [DW:0]          out_data_q, out_data_d;
  logic                 out_push_s, out_pop_s;

  // One output slot stays reserved for the pixel already sitting in the stage register.
  assign in_wr_s   = fifo_in_wrreq && !in_full_q;
  assign in_pop_s  = !in_empty_q && (out_cnt_q <= OUT_LIMIT);
  assign in_head_s = in_mem_q[in_rd_ptr_q];
  assign pix_s     = smax(smax(signed'(in_head_s[DW-1:0]), signed'(in_head_s[2*DW-1:DW])),
                          signed'(in_head_s[3*DW-1:2*DW]));

  // Input occupancy next-state
  always_comb begin
    in_cnt_d = in_cnt_q;
    case ({in_wr_s, in_pop_s})
      2'b10:   in_cnt_d = in_cnt_q + IN_ONE;
      2'b01:   in_cnt_d = in_cnt_q - IN_ONE;
      default: in_cnt_d = in_cnt_q;
    endcase
  end

  // Input FIFO pointers and flags
  always_ff @(posedge clock) begin
    if (resetn) begin
      in_wr_ptr_q <= {IAW{1'b0}};
      in_rd_ptr_q <= {IAW{1'b0}};
      in_cnt_q    <= {(IAW+1){1'b0}};
      in_full_q   <= 1'b0;
      in_empty_q  <= 1'b1;
    end else begin
      if (in_wr_s) in_wr_ptr_q <= in_wr_ptr_q + IAW'(1);
      if (in_pop_s) in_rd_ptr_q <= in_rd_ptr_q + IAW'(1);
      in_cnt_q   <= in_cnt_d;
      in_full_q  <= (in_cnt_d == IN_FULL);
      in_empty_q <= (in_cnt_d == {(IAW+1){1'b0}});
    end
  end

  // Input FIFO storage
  always_ff @(posedge clock) begin
    if (in_wr_s) in_mem_q[in_wr_ptr_q] <= {fifo_in_data_2, fifo_in_data_1, fifo_in_data_0};
  end

  // Raster position tracking and stage register load
  always_ff @(posedge clock) begin
    if (resetn) begin
      x_q        <= {XW{1'b0}};
      y_q        <= {YW{1'b0}};
      st_valid_q <= 1'b0;
      st_first_q <= 1'b0;
      st_last_q  <= 1'b0;
      st_class_q <= 1'b0;
      st_bx_q    <= {BW{1'b0}};
      st_p_q     <= {DW{1'b0}};
    end else begin
      st_valid_q <= in_pop_s;
      if (in_pop_s) begin
        st_p_q     <= pix_s;
        st_bx_q    <= BW'(x_q >> 3'd5);
        st_first_q <= (x_q[4:0] == 5'd0) && (y_q[4:0] == 5'd0);
        st_last_q  <= (x_q[4:0] == 5'd31) && (y_q[4:0] == 5'd31);
        st_class_q <= (x_q == X_LAST) && (y_q == Y_LAST);
        if (x_q == X_LAST) begin
          x_q <= {XW{1'b0}};
          y_q <= (y_q == Y_LAST) ? {YW{1'b0}} : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

  // The tile's first pixel restarts its column accumulator, which makes reset of acc unnecessary.
  assign acc_cur_s   = acc_q[st_bx_q];
  assign acc_new_s   = st_first_q ? st_p_q : smax(acc_cur_s, st_p_q);
  assign push_s      = st_valid_q && st_last_q;
  assign push_data_s = {st_class_q, acc_new_s};

  // Tile-column accumulator update
  always_ff @(posedge clock) begin
    if (st_valid_q) acc_q[st_bx_q] <= acc_new_s;
  end

  assign out_pop_s    = fifo_out_rdreq && !out_empty_q;
  assign out_push_s   = push_s && ((out_cnt_q != OUT_FULL) || out_pop_s);
  assign out_rd_nxt_s = out_rd_ptr_q + OAW'(1);

  // Output occupancy and registered head-of-queue word
  always_comb begin
    out_cnt_d  = out_cnt_q;
    out_data_d = out_data_q;
    case ({out_push_s, out_pop_s})
      2'b10:   out_cnt_d = out_cnt_q + OUT_ONE;
      2'b01:   out_cnt_d = out_cnt_q - OUT_ONE;
      default: out_cnt_d = out_cnt_q;
    endcase
    if (out_push_s && (out_empty_q || (out_pop_s && (out_cnt_q == OUT_ONE)))) begin
      out_data_d = push_data_s;
    end else if (out_pop_s && (out_cnt_q != OUT_ONE)) begin
      out_data_d = out_mem_q[out_rd_nxt_s];
    end else begin
      out_data_d = out_data_q;
    end
  end

  // Output FIFO pointers and flags
  always_ff @(posedge clock) begin
    if (resetn) begin
      out_wr_ptr_q <= {OAW{1'b0}};
      out_rd_ptr_q <= {OAW{1'b0}};
      out_cnt_q    <= {(OAW+1){1'b0}};
      out_empty_q  <= 1'b1;
      out_data_q   <= {(DW+1){1'b0}};
    end else begin
      if (out_push_s) out_wr_ptr_q <= out_wr_ptr_q + OAW'(1);
      if (out_pop_s) out_rd_ptr_q <= out_rd_nxt_s;
      out_cnt_q   <= out_cnt_d;
      out_empty_q <= (out_cnt_d == {(OAW+1){1'b0}});
      out_data_q  <= out_data_d;
    end
  end

  // Output FIFO storage
  always_ff @(posedge clock) begin
    if (out_push_s) out_mem_q[out_wr_ptr_q] <= push_data_s;
  end

  assign fifo_in_full   = in_full_q;
  assign fifo_out_empty = out_empty_q;
  assign fifo_out_data  = out_data_q;

endmodule

// File: tb/tb_vip_pool_top.sv
// Directed bench for vip_pool_top configured as a 64x32 image with a 4-deep result FIFO.
module tb_vip_pool_top;

  logic        clock;
  logic        resetn;
  logic [31:0] d0, d1, d2;
  logic        wrreq, rdreq;
  logic        in_full, out_empty;
  logic [32:0] out_data;

  int          checks;
  int          errors;
  logic [32:0] got [$];

  vip_pool_top #(
    .WIDTH(64), .HEIGHT(32), .DATA_WIDTH(32), .IN_DEPTH(16), .OUT_DEPTH(4)
  ) u_dut (
    .clock          (clock),
    .resetn         (resetn),
    .fifo_in_data_0 (d0),
    .fifo_in_data_1 (d1),
    .fifo_in_data_2 (d2),
    .fifo_in_wrreq  (wrreq),
    .fifo_in_full   (in_full),
    .fifo_out_data  (out_data),
    .fifo_out_rdreq (rdreq),
    .fifo_out_empty (out_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] pick(input int i);
    if (i < got.size()) return got[i];
    return {33{1'bx}};
  endfunction

  // Record the head word if it is popped by the rdreq value about to be driven.
  task automatic cap(input logic rd);
    if (rd && !out_empty) got.push_back(out_data);
  endtask

  task automatic drv(input logic wr, input logic [31:0] c0, input logic [31:0] c1,
                     input logic [31:0] c2, input logic rd);
    wrreq = wr; d0 = c0; d1 = c1; d2 = c2; rdreq = rd;
  endtask

  task automatic idle(input int n, input logic rd);
    repeat (n) begin
      @(negedge clock); cap(rd); drv(1'b0, 32'd0, 32'd0, 32'd0, rd);
    end
  endtask

  task automatic put_px(input logic [31:0] c0, input logic [31:0] c1,
                        input logic [31:0] c2, input logic rd);
    int g;
    g = 0;
    @(negedge clock); cap(rd);
    while (in_full && g < 500) begin
      drv(1'b0, 32'd0, 32'd0, 32'd0, rd);
      @(negedge clock); cap(rd);
      g++;
    end
    if (g >= 500) begin
      errors++;
      $display("FAIL put_px_timeout observed=full expected=not_full");
    end
    drv(1'b1, c0, c1, c2, rd);
  endtask

  task automatic drain(input int n);
    int g;
    g = 0;
    while (got.size() < n && g < 300) begin
      @(negedge clock); cap(1'b1); drv(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
      g++;
    end
    idle(8, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b1;
    drv(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    got.delete();
  endtask

  initial begin
    int  idx;
    bit  full_seen;
    checks = 0;
    errors = 0;
    resetn = 1'b1;
    drv(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

    // Reset values, then rdreq on an empty FIFO
    do_reset();
    chk("rst_full",  {32'd0, in_full},   33'd0);
    chk("rst_empty", {32'd0, out_empty}, 33'd1);
    chk("rst_data",  out_data,           33'd0);
    idle(2, 1'b1);
    chk("rd_empty_flag", {32'd0, out_empty}, 33'd1);
    chk("rd_empty_data", out_data,           33'd0);

    // ch0 = x+y, ch1 = 0, ch2 = -1
    got.delete();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++)
        put_px(32'(x + y), 32'd0, 32'hFFFF_FFFF, 1'b1);
    drain(2);
    chk("ramp_count", 33'(got.size()), 33'd2);
    chk("ramp_res0",  pick(0), {1'b0, 32'd62});
    chk("ramp_res1",  pick(1), {1'b1, 32'd94});

    // All channels -5
    got.delete();
    for (int i = 0; i < 2048; i++) put_px(32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 1'b1);
    drain(2);
    chk("neg_count", 33'(got.size()), 33'd2);
    chk("neg_res0",  pick(0), {1'b0, 32'hFFFF_FFFB});
    chk("neg_res1",  pick(1), {1'b1, 32'hFFFF_FFFB});

    // Back-to-back images: 100 everywhere, then all zeros
    got.delete();
    for (int i = 0; i < 2048; i++) put_px(32'd100, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 2048; i++) put_px(32'd0, 32'd0, 32'd0, 1'b1);
    drain(4);
    chk("b2b_count", 33'(got.size()), 33'd4);
    chk("b2b_res0",  pick(0), {1'b0, 32'd100});
    chk("b2b_res1",  pick(1), {1'b1, 32'd100});
    chk("b2b_res2",  pick(2), {1'b0, 32'd0});
    chk("b2b_res3",  pick(3), {1'b1, 32'd0});

    // Backpressure: no reads until the input FIFO is full
    got.delete();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++)
        put_px(32'(x), 32'(y), 32'd0, 1'b0);
    idx = 0;
    full_seen = 1'b0;
    while (!full_seen && idx < 2048) begin
      @(negedge clock); cap(1'b0);
      if (in_full) begin
        full_seen = 1'b1;
        drv(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      end else begin
        drv(1'b1, 32'(1000 + idx % 64), 32'(idx / 64), 32'd0, 1'b0);
        idx++;
      end
    end
    chk("bp_in_full",   {32'd0, in_full},   33'd1);
    chk("bp_out_empty", {32'd0, out_empty}, 33'd0);
    chk("bp_head",      out_data,           {1'b0, 32'd31});
    repeat (3) begin
      @(negedge clock); cap(1'b0);
      drv(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    end
    idle(4, 1'b0);
    chk("bp_still_full", {32'd0, in_full}, 33'd1);
    for (int i = idx; i < 2048; i++) put_px(32'(1000 + i % 64), 32'(i / 64), 32'd0, 1'b1);
    drain(4);
    chk("bp_count", 33'(got.size()), 33'd4);
    chk("bp_res0",  pick(0), {1'b0, 32'd31});
    chk("bp_res1",  pick(1), {1'b1, 32'd63});
    chk("bp_res2",  pick(2), {1'b0, 32'd1031});
    chk("bp_res3",  pick(3), {1'b1, 32'd1063});

    // Reset mid-image, then a full image of ch1 = 7
    got.delete();
    for (int i = 0; i < 500; i++) put_px(32'd555, 32'd0, 32'd0, 1'b1);
    do_reset();
    chk("mid_rst_empty", {32'd0, out_empty}, 33'd1);
    chk("mid_rst_full",  {32'd0, in_full},   33'd0);
    for (int i = 0; i < 2048; i++) put_px(32'd0, 32'd7, 32'd0, 1'b1);
    drain(2);
    chk("mid_count", 33'(got.size()), 33'd2);
    chk("mid_res0",  pick(0), {1'b0, 32'd7});
    chk("mid_res1",  pick(1), {1'b1, 32'd7});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
